// File: rtl/lfrag_cfg_loader_if.sv
// Serial configuration stream and committed LUT-word bus between a bitstream
// source (master) and lfrag_cfg_loader (slave).
interface lfrag_cfg_loader_if #(
  parameter int NUM_CELLS = 4
);
  logic                      cfg_start;
  logic                      cfg_din;
  logic                      cfg_valid;
  logic                      cfg_ready;
  logic [16*NUM_CELLS-1:0]   lFragBitInfo;
  logic                      cfg_busy;
  logic                      cfg_done;
  logic                      cfg_err;

  modport master (
    output cfg_start, cfg_din, cfg_valid,
    input  cfg_ready, lFragBitInfo, cfg_busy, cfg_done, cfg_err
  );

  modport slave (
    input  cfg_start, cfg_din, cfg_valid,
    output cfg_ready, lFragBitInfo, cfg_busy, cfg_done, cfg_err
  );
endinterface

// File: rtl/lfrag_cfg_loader.sv
// Deserialises a framed LUT bitstream, verifies its byte-sum checksum and
// commits all cell words to lFragBitInfo in one cycle.
//
// state    | meaning
// ST_IDLE  | waiting for cfg_start after reset
// ST_SHIFT | accepting frame bits
// ST_CHECK | frame complete, comparing checksum
// ST_DONE  | last frame committed
// ST_ERROR | last frame rejected, previous words kept
module lfrag_cfg_loader #(
  parameter int NUM_CELLS = 4,
  parameter bit CHK_EN    = 1'b1
) (
  input  logic              QCK,
  input  logic              QRT,
  lfrag_cfg_loader_if.slave cfg
);
  localparam int DATA_BITS  = 16 * NUM_CELLS;
  localparam int FRAME_BITS = DATA_BITS + (CHK_EN ? 8 : 0);
  localparam int CNT_W      = $clog2(16 * NUM_CELLS + 8 + 1);
  localparam int WORD_W     = CNT_W - 4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SHIFT,
    ST_CHECK,
    ST_DONE,
    ST_ERROR
  } state_t;

  state_t               state;
  state_t               state_nxt;
  logic [CNT_W-1:0]     bit_cnt;
  logic [15:0]          stage;
  logic [DATA_BITS-1:0] shadow;
  logic [DATA_BITS-1:0] lfrag;
  logic [7:0]           sum;
  logic [7:0]           rx_chk;
  logic                 ready;
  logic                 busy;
  logic                 done;
  logic                 err;
  logic                 accept;
  logic                 last_bit;
  logic                 chk_ok;
  logic [15:0]          word_nxt;
  logic [WORD_W-1:0]    word_idx;

  assign accept   = cfg.cfg_valid && ready;
  assign last_bit = (bit_cnt == CNT_W'(FRAME_BITS - 1));
  assign word_nxt = {stage[14:0], cfg.cfg_din};
  assign word_idx = bit_cnt[CNT_W-1:4];
  assign chk_ok   = !CHK_EN || (sum == rx_chk);

  assign cfg.cfg_ready    = ready;
  assign cfg.cfg_busy     = busy;
  assign cfg.cfg_done     = done;
  assign cfg.cfg_err      = err;
  assign cfg.lFragBitInfo = lfrag;

  always_ff @(posedge QCK or posedge QRT) begin
    if (QRT) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    ready     = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    err       = 1'b0;
    case (state)
      ST_IDLE: ;
      ST_SHIFT: begin
        busy  = 1'b1;
        ready = !cfg.cfg_start;
        if (accept && last_bit) begin
          state_nxt = ST_CHECK;
        end
      end
      ST_CHECK: begin
        busy      = 1'b1;
        state_nxt = chk_ok ? ST_DONE : ST_ERROR;
      end
      ST_DONE:  done = 1'b1;
      ST_ERROR: err  = 1'b1;
      default:  state_nxt = ST_IDLE;
    endcase
    // A start pulse overrides every other transition, including a pending check.
    if (cfg.cfg_start) begin
      state_nxt = ST_SHIFT;
    end
  end

  always_ff @(posedge QCK or posedge QRT) begin
    if (QRT) begin
      bit_cnt <= '0;
      stage   <= '0;
      shadow  <= '0;
      sum     <= '0;
      rx_chk  <= '0;
      lfrag   <= '0;
    end else if (cfg.cfg_start) begin
      bit_cnt <= '0;
      stage   <= '0;
      shadow  <= '0;
      sum     <= '0;
      rx_chk  <= '0;
    end else begin
      if (accept) begin
        bit_cnt <= bit_cnt + 1'b1;
        if (bit_cnt < CNT_W'(DATA_BITS)) begin
          stage <= word_nxt;
          if (bit_cnt[3:0] == 4'hF) begin
            for (int i = 0; i < NUM_CELLS; i++) begin
              if (word_idx == WORD_W'(i)) begin
                shadow[16*i +: 16] <= word_nxt;
              end
            end
            sum <= sum + word_nxt[15:8] + word_nxt[7:0];
          end
        end else begin
          rx_chk <= {rx_chk[6:0], cfg.cfg_din};
        end
      end
      // Commit coincides with the CHECK -> DONE transition.
      if (state == ST_CHECK && chk_ok) begin
        lfrag <= shadow;
      end
    end
  end
endmodule

// File: tb/tb_lfrag_cfg_loader.sv
// Directed and randomized frames against a byte-sum reference model for a
// 4-cell checksummed loader and a 1-cell unchecked loader.
module tb_lfrag_cfg_loader;
  logic QCK = 1'b0;
  logic QRT;
  always #5 QCK = ~QCK;

  lfrag_cfg_loader_if #(.NUM_CELLS(4)) ifa ();
  lfrag_cfg_loader_if #(.NUM_CELLS(1)) ifb ();

  lfrag_cfg_loader #(.NUM_CELLS(4), .CHK_EN(1'b1)) dut_a (
    .QCK(QCK), .QRT(QRT), .cfg(ifa.slave)
  );
  lfrag_cfg_loader #(.NUM_CELLS(1), .CHK_EN(1'b0)) dut_b (
    .QCK(QCK), .QRT(QRT), .cfg(ifb.slave)
  );

  int          n_pass = 0;
  int          n_total = 0;
  logic [63:0] exp_lfrag;
  bit          frame_q[$];

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %b expected %b", tag, obs, exp);
  endtask

  task automatic chkw(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  function automatic logic [7:0] byte_sum(input logic [15:0] w [4]);
    int s;
    s = 0;
    for (int i = 0; i < 4; i++) s = (s + int'(w[i][15:8]) + int'(w[i][7:0])) % 256;
    return 8'(s);
  endfunction

  task automatic make_frame(input logic [15:0] w [4], input logic [7:0] ck);
    frame_q.delete();
    for (int c = 0; c < 4; c++)
      for (int b = 15; b >= 0; b--) frame_q.push_back(w[c][b]);
    for (int b = 7; b >= 0; b--) frame_q.push_back(ck[b]);
  endtask

  // Called at a falling edge; returns 1 time unit after the next falling edge.
  task automatic start_a(input logic v);
    ifa.cfg_start = 1'b1;
    ifa.cfg_valid = v;
    ifa.cfg_din   = 1'b1;
    #1 chk1("ready_low_during_start", ifa.cfg_ready, 1'b0);
    @(negedge QCK);
    ifa.cfg_start = 1'b0;
    ifa.cfg_valid = 1'b0;
    #1;
    chk1("busy_after_start", ifa.cfg_busy, 1'b1);
    chk1("done_clr_on_start", ifa.cfg_done, 1'b0);
    chk1("err_clr_on_start", ifa.cfg_err, 1'b0);
    chk1("ready_in_shift", ifa.cfg_ready, 1'b1);
    chkw("lfrag_held_on_start", ifa.lFragBitInfo, exp_lfrag);
  endtask

  task automatic send_bits_a(input int n, input int gmin, input int gmax);
    for (int i = 0; i < n; i++) begin
      int g;
      g = $urandom_range(gmin, gmax);
      repeat (g) begin
        ifa.cfg_valid = 1'b0;
        ifa.cfg_din   = 1'($urandom);
        @(negedge QCK);
      end
      ifa.cfg_valid = 1'b1;
      ifa.cfg_din   = frame_q[i];
      #1 chk1("ready_while_shifting", ifa.cfg_ready, 1'b1);
      @(negedge QCK);
    end
    ifa.cfg_valid = 1'b0;
  endtask

  // Called at the falling edge after the last frame bit was accepted.
  task automatic finish_a(input logic [15:0] w [4], input logic [7:0] ck);
    bit good;
    good = (ck == byte_sum(w));
    #1;
    chk1("check_busy", ifa.cfg_busy, 1'b1);
    chk1("check_not_done", ifa.cfg_done, 1'b0);
    chk1("check_ready_low", ifa.cfg_ready, 1'b0);
    chkw("check_lfrag_old", ifa.lFragBitInfo, exp_lfrag);
    if (good) exp_lfrag = {w[3], w[2], w[1], w[0]};
    @(negedge QCK);
    #1;
    chk1("result_done", ifa.cfg_done, good);
    chk1("result_err", ifa.cfg_err, !good);
    chk1("result_busy", ifa.cfg_busy, 1'b0);
    chk1("result_ready", ifa.cfg_ready, 1'b0);
    chkw("result_lfrag", ifa.lFragBitInfo, exp_lfrag);
  endtask

  task automatic run_frame_a(input logic [15:0] w [4], input logic [7:0] ck,
                             input int gmin, input int gmax);
    start_a(1'b0);
    make_frame(w, ck);
    send_bits_a(72, gmin, gmax);
    finish_a(w, ck);
  endtask

  initial begin
    logic [15:0] w_good [4];
    logic [15:0] w_55 [4];
    logic [15:0] w_rnd [4];
    logic [15:0] word_b;
    logic [7:0]  ck;

    w_good = '{16'h8000, 16'h0001, 16'hFFFF, 16'h1234};
    w_55   = '{16'h5555, 16'h5555, 16'h5555, 16'h5555};
    word_b = 16'hA5C3;
    exp_lfrag = '0;
    QRT = 1'b1;
    ifa.cfg_start = 1'b0; ifa.cfg_valid = 1'b0; ifa.cfg_din = 1'b0;
    ifb.cfg_start = 1'b0; ifb.cfg_valid = 1'b0; ifb.cfg_din = 1'b0;
    repeat (2) @(negedge QCK);
    chkw("rst_lfrag", ifa.lFragBitInfo, 64'h0);
    chk1("rst_ready", ifa.cfg_ready, 1'b0);
    chk1("rst_busy", ifa.cfg_busy, 1'b0);
    chk1("rst_done", ifa.cfg_done, 1'b0);
    chk1("rst_err", ifa.cfg_err, 1'b0);
    QRT = 1'b0;
    @(negedge QCK);
    chk1("idle_ready", ifa.cfg_ready, 1'b0);

    // Reference frame, no gaps.
    run_frame_a(w_good, 8'hC5, 0, 0);
    chkw("t1_lfrag_const", ifa.lFragBitInfo, 64'h1234_FFFF_0001_8000);
    @(negedge QCK);

    // All-0x5555 load, then the reference words with a bad checksum.
    run_frame_a(w_55, byte_sum(w_55), 0, 0);
    @(negedge QCK);
    run_frame_a(w_good, 8'hC4, 0, 0);
    chkw("t2_lfrag_kept", ifa.lFragBitInfo, 64'h5555_5555_5555_5555);
    chk1("t2_err_const", ifa.cfg_err, 1'b1);
    @(negedge QCK);

    // Toggling valid, then random gaps.
    run_frame_a(w_good, 8'hC5, 1, 1);
    @(negedge QCK);
    run_frame_a(w_55, 8'hA8, 0, 3);
    @(negedge QCK);
    run_frame_a(w_good, 8'hC5, 0, 3);
    chkw("t3_lfrag_const", ifa.lFragBitInfo, 64'h1234_FFFF_0001_8000);
    @(negedge QCK);

    // Abort during CHECK: the 0x5555 frame must not commit.
    start_a(1'b0);
    make_frame(w_55, 8'hA8);
    send_bits_a(72, 0, 0);
    start_a(1'b0);
    for (int i = 0; i < 4; i++) w_rnd[i] = 16'($urandom);
    make_frame(w_rnd, byte_sum(w_rnd));
    send_bits_a(72, 0, 1);
    finish_a(w_rnd, byte_sum(w_rnd));
    @(negedge QCK);

    // Restart after 20 garbage bits, start with valid high drops that bit.
    start_a(1'b0);
    for (int i = 0; i < 4; i++) w_rnd[i] = 16'($urandom);
    make_frame(w_rnd, 8'($urandom));
    send_bits_a(20, 0, 0);
    start_a(1'b1);
    make_frame(w_good, 8'hC5);
    send_bits_a(72, 0, 0);
    finish_a(w_good, 8'hC5);
    @(negedge QCK);

    // Reset after 40 bits.
    start_a(1'b0);
    make_frame(w_55, 8'hA8);
    send_bits_a(40, 0, 0);
    QRT = 1'b1;
    #1;
    exp_lfrag = '0;
    chkw("midrst_lfrag", ifa.lFragBitInfo, 64'h0);
    chk1("midrst_ready", ifa.cfg_ready, 1'b0);
    chk1("midrst_busy", ifa.cfg_busy, 1'b0);
    chk1("midrst_done", ifa.cfg_done, 1'b0);
    @(negedge QCK);
    QRT = 1'b0;
    @(negedge QCK);
    chk1("postrst_ready", ifa.cfg_ready, 1'b0);
    chk1("postrst_busy", ifa.cfg_busy, 1'b0);
    run_frame_a(w_good, 8'hC5, 0, 1);
    @(negedge QCK);

    // Random frames, about a third carry a corrupted checksum.
    for (int f = 0; f < 6; f++) begin
      for (int i = 0; i < 4; i++) w_rnd[i] = 16'($urandom);
      ck = byte_sum(w_rnd);
      if ($urandom_range(0, 2) == 0) ck = ck ^ 8'($urandom_range(1, 255));
      run_frame_a(w_rnd, ck, 0, 2);
      @(negedge QCK);
    end

    // Single-cell loader without checksum.
    chk1("b_idle_ready", ifb.cfg_ready, 1'b0);
    ifb.cfg_start = 1'b1;
    @(negedge QCK);
    ifb.cfg_start = 1'b0;
    for (int b = 15; b >= 0; b--) begin
      ifb.cfg_valid = 1'b1;
      ifb.cfg_din   = word_b[b];
      #1 chk1("b_ready", ifb.cfg_ready, 1'b1);
      @(negedge QCK);
    end
    ifb.cfg_valid = 1'b0;
    #1;
    chk1("b_check_busy", ifb.cfg_busy, 1'b1);
    chk1("b_check_done", ifb.cfg_done, 1'b0);
    chkw("b_check_lfrag", 64'(ifb.lFragBitInfo), 64'h0);
    @(negedge QCK);
    #1;
    chk1("b_done", ifb.cfg_done, 1'b1);
    chk1("b_err", ifb.cfg_err, 1'b0);
    chk1("b_busy", ifb.cfg_busy, 1'b0);
    chkw("b_lfrag", 64'(ifb.lFragBitInfo), 64'h0000_0000_0000_A5C3);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/lfrag_cfg_loader.md
# lfrag_cfg_loader

Serial configuration loader that sits directly upstream of a row of `ONE_LOGIC_CELL` instances and produces their 16-bit `lFragBitInfo` LUT words.
- It deserialises a framed bitstream (NUM_CELLS LUT words plus an optional 8-bit checksum) under a valid/ready handshake.
- It verifies the checksum and then commits all words atomically to the output bus, so downstream cells never see a partially loaded configuration.

## Interface
Parameters:
- NUM_CELLS, 4, number of logic cells fed; legal range 1..16.
- CHK_EN, 1, 1 = frame carries a trailing 8-bit checksum that is verified; 0 = no checksum bits, frame always passes.

Ports:
- QCK  input  1  clock; all state updates on the rising edge.
- QRT  input  1  reset, asynchronous, active-high.
- cfg_start  input  1  single-cycle pulse that begins (or restarts) frame reception.
- cfg_din  input  1  serial data bit.
- cfg_valid  input  1  cfg_din is valid this cycle.
- cfg_ready  output  1  loader accepts a bit this cycle.
- lFragBitInfo  output  16*NUM_CELLS  committed LUT words; cell i is bits [16*i+15 : 16*i].
- cfg_busy  output  1  frame reception or check in progress.
- cfg_done  output  1  last frame committed successfully; sticky.
- cfg_err  output  1  last frame failed its checksum; sticky.

## Operation
- FSM states and transitions:
  - IDLE: cfg_start → SHIFT.
  - SHIFT: after the final frame bit is accepted → CHECK.
  - CHECK: checksum matches → DONE; otherwise → ERROR.
  - DONE / ERROR: cfg_start → SHIFT.
- cfg_start in any state restarts reception.
  - Bit counter, staging word, shadow words and running sum are cleared; next state is SHIFT.
  - The committed lFragBitInfo is unchanged.
- Handshake:
  - cfg_ready = (state == SHIFT) && !cfg_start, combinational.
  - A bit is accepted on a rising edge where cfg_valid && cfg_ready.
  - cfg_valid gaps are allowed with no limit.
  - Bits offered while cfg_ready = 0 are ignored.
- Frame order:
  - Cell 0 word first, cell NUM_CELLS-1 last; each word is sent MSB (bit 15) first.
  - When CHK_EN = 1, the checksum byte follows, MSB first.
  - Total frame length is 16*NUM_CELLS + 8*CHK_EN bits.
- Deserialisation:
  - Bits shift into a 16-bit staging register.
  - On the 16th bit of a word, the staging value is written to shadow[word_idx] and word_idx increments.
- Checksum: the byte sum modulo 256 of every data byte, high byte then low byte of each word, in frame order.
  - Accumulated in an 8-bit register as each word completes.
  - The received checksum is shifted into a separate 8-bit register.
- Commit: on the CHECK → DONE edge, all shadow words are copied to lFragBitInfo in a single cycle.
- ERROR leaves lFragBitInfo at its previous committed value.
- CHK_EN = 0: CHECK always goes to DONE.
- Flags:
  - cfg_busy = 1 in SHIFT and CHECK.
  - cfg_done = 1 only in DONE; cfg_err = 1 only in ERROR.
  - Both flags clear on the edge that accepts cfg_start.
- Counter width: bit counter is clog2(16*NUM_CELLS+8+1) bits; no wrap is possible inside a legal frame.

## Timing
- Reset (QRT high, asynchronous):
  - state = IDLE.
  - lFragBitInfo = 0; cfg_ready, cfg_busy, cfg_done and cfg_err = 0.
  - Counters, shadow and sum registers = 0.
- Reset takes effect immediately, including mid-frame; the partial frame is discarded.
- First accepted bit is possible on the edge one cycle after the edge that samples cfg_start.
- Latency from the last frame bit accepted at edge k:
  - CHECK during cycle k..k+1.
  - At edge k+1, state becomes DONE/ERROR and lFragBitInfo updates together with cfg_done/cfg_err.
- cfg_start and cfg_valid in the same cycle: start wins and the bit is not accepted.
- cfg_start in CHECK aborts the check; no commit, no flag.
- A new frame after DONE keeps the old lFragBitInfo until its own successful commit.

## Test plan
- NUM_CELLS=4, CHK_EN=1; words 0x8000, 0x0001, 0xFFFF, 0x1234 then checksum 0xC5, cfg_valid held high → 72 bits accepted; edge after the last bit: cfg_done=1, lFragBitInfo = 0x1234_FFFF_0001_8000, cfg_busy=0.
- Same frame with checksum 0xC4, sent after a successful load of all-0x5555 words → cfg_err=1, cfg_done=0, lFragBitInfo stays 0x5555_5555_5555_5555.
- Same good frame with cfg_valid toggling 1,0,1,0 and random 0-3 cycle gaps → identical result as the first test; cfg_ready never high outside SHIFT.
- Restart: send 20 bits of garbage, pulse cfg_start with cfg_valid=1 in the same cycle (bit dropped), then the full good frame → cfg_done=1, correct words.
- Reset mid-frame: QRT high after 40 bits → outputs 0 immediately, state IDLE, cfg_ready=0; a later cfg_start plus the good frame loads correctly.
- NUM_CELLS=1, CHK_EN=0; word 0xA5C3 → cfg_done at the edge after the 16th bit; lFragBitInfo = 0xA5C3.
